// File: rtl/sram_port_arbiter_pkg.sv
// Shared types and constants for the two-channel asynchronous SRAM port arbiter.
package sram_port_arbiter_pkg;

    localparam int DEF_AW = 11;
    localparam int DEF_DW = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_STROBE = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

    // Counter runs 0..cycles-1, so it needs enough bits for cycles-1.
    function automatic int cnt_width(input int cycles);
        return (cycles <= 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/sram_port_arbiter_if.sv
// Requester-side bundle: two request channels plus shared completion/status.
interface sram_port_arbiter_if
    import sram_port_arbiter_pkg::*;
#(
    parameter int AW = DEF_AW,
    parameter int DW = DEF_DW
);
    logic [1:0]         req;
    logic [1:0]         we;
    logic [1:0][AW-1:0] addr;
    logic [1:0][DW-1:0] wdata;
    logic [1:0]         done;
    logic [DW-1:0]      rdata;
    logic               busy;

    modport master (output req, we, addr, wdata, input done, rdata, busy);
    modport slave  (input req, we, addr, wdata, output done, rdata, busy);
endinterface

// File: rtl/sram_port_arbiter_rr_arb2.sv
// Combinational two-way round-robin picker: on contention the channel that
// did not win last time is chosen.
module sram_port_arbiter_rr_arb2 (
    input  logic [1:0] i_req,
    input  logic       i_last,
    output logic [1:0] o_grant,
    output logic       o_winner
);
    logic w_winner;

    always_comb begin
        w_winner = 1'b0;
        if (i_req == 2'b11) begin
            w_winner = ~i_last;
        end else if (i_req[1]) begin
            w_winner = 1'b1;
        end
    end

    assign o_winner = w_winner;
    assign o_grant  = (i_req == 2'b00) ? 2'b00 : (w_winner ? 2'b10 : 2'b01);

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one asynchronous SRAM between two channels; each access runs
// SETUP / STROBE / HOLD with every SRAM-facing signal driven from a flop.
module sram_port_arbiter
    import sram_port_arbiter_pkg::*;
#(
    parameter int AW         = DEF_AW,
    parameter int DW         = DEF_DW,
    parameter int STROBE_CYC = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    sram_port_arbiter_if.slave bus,
    output logic [AW-1:0]     o_address,
    inout  wire  [DW-1:0]     io_sram_data,
    output logic              o_rd_n,
    output logic              o_wr_n,
    output logic              o_data_oe
);
    localparam int            CW       = cnt_width(STROBE_CYC);
    localparam logic [CW-1:0] CNT_LAST = CW'(STROBE_CYC - 1);

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic          r_last;
    logic          r_gnt;
    logic          r_we;
    logic [DW-1:0] r_wdata;
    logic [DW-1:0] r_rdata;
    logic [AW-1:0] r_address;
    logic          r_rd_n;
    logic          r_wr_n;
    logic          r_oe;
    logic [1:0]    r_done;

    logic [1:0]    w_grant;
    logic          w_winner;

    sram_port_arbiter_rr_arb2 u_rr (
        .i_req    (bus.req),
        .i_last   (r_last),
        .o_grant  (w_grant),
        .o_winner (w_winner)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_last    <= 1'b1;
            r_gnt     <= 1'b0;
            r_we      <= 1'b0;
            r_wdata   <= '0;
            r_rdata   <= '0;
            r_address <= '0;
            r_rd_n    <= 1'b1;
            r_wr_n    <= 1'b1;
            r_oe      <= 1'b0;
            r_done    <= 2'b00;
        end else begin
            r_done <= 2'b00;
            case (r_state)
                ST_IDLE: begin
                    // Command is captured here; channel inputs are ignored until the next grant.
                    if (|w_grant) begin
                        r_state   <= ST_SETUP;
                        r_last    <= w_winner;
                        r_gnt     <= w_winner;
                        r_we      <= bus.we[w_winner];
                        r_address <= bus.addr[w_winner];
                        r_wdata   <= bus.wdata[w_winner];
                        r_oe      <= bus.we[w_winner];
                    end
                end
                ST_SETUP: begin
                    r_state <= ST_STROBE;
                    r_cnt   <= '0;
                    if (r_we) begin
                        r_wr_n <= 1'b0;
                    end else begin
                        r_rd_n <= 1'b0;
                    end
                end
                ST_STROBE: begin
                    if (r_cnt == CNT_LAST) begin
                        // rd is still low up to this edge, so the SRAM is still driving the bus.
                        r_state         <= ST_HOLD;
                        r_rd_n          <= 1'b1;
                        r_wr_n          <= 1'b1;
                        r_done[r_gnt]   <= 1'b1;
                        if (!r_we) begin
                            r_rdata <= io_sram_data;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_HOLD: begin
                    r_state <= ST_IDLE;
                    r_oe    <= 1'b0;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign io_sram_data = r_oe ? r_wdata : {DW{1'bz}};
    assign o_address    = r_address;
    assign o_rd_n       = r_rd_n;
    assign o_wr_n       = r_wr_n;
    assign o_data_oe    = r_oe;
    assign bus.done     = r_done;
    assign bus.rdata    = r_rdata;
    assign bus.busy     = (r_state != ST_IDLE);

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with a behavioural asynchronous SRAM.
module tb_sram_port_arbiter;

    logic        clk;
    logic        rst_n;
    logic        mem_init;
    logic [10:0] o_address;
    wire  [7:0]  sram_data;
    logic        o_rd_n;
    logic        o_wr_n;
    logic        o_data_oe;

    int errors = 0;
    int checks = 0;
    logic        prev_busy = 1'b0;
    logic [10:0] prev_addr = '0;

    sram_port_arbiter_if #(.AW(11), .DW(8)) bus ();

    sram_port_arbiter #(.AW(11), .DW(8), .STROBE_CYC(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .o_address    (o_address),
        .io_sram_data (sram_data),
        .o_rd_n       (o_rd_n),
        .o_wr_n       (o_wr_n),
        .o_data_oe    (o_data_oe)
    );

    // SRAM model: drives the bus while rd is low, stores while wr is low.
    logic [7:0] mem [0:2047];
    assign sram_data = o_rd_n ? 8'hzz : mem[o_address];

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 2048; i++) mem[i] <= 8'h00;
            mem[11'h7FF] <= 8'h5A;
        end else if (!o_wr_n) begin
            mem[o_address] <= sram_data;
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance to the next falling edge and apply the always-on bus invariants.
    task automatic tick();
        @(negedge clk);
        if (rst_n) begin
            check("rdwr_excl", 32'(o_rd_n | o_wr_n), 32'd1);
            check("oe_busy", 32'(o_data_oe & ~bus.busy), 32'd0);
            check("oe_rd", 32'(o_data_oe & ~o_rd_n), 32'd0);
            if (prev_busy && bus.busy) check("addr_stable", 32'(o_address), 32'(prev_addr));
        end
        prev_busy = bus.busy;
        prev_addr = o_address;
    endtask

    // Single-channel access from IDLE, checked cycle by cycle.
    task automatic access(input int ch, input logic we, input logic [10:0] addr,
                          input logic [7:0] wd, input logic [7:0] exp_rd);
        bus.req       = 2'b00;
        bus.req[ch]   = 1'b1;
        bus.we[ch]    = we;
        bus.addr[ch]  = addr;
        bus.wdata[ch] = wd;
        tick();
        check("setup_addr", 32'(o_address), 32'(addr));
        check("setup_busy", 32'(bus.busy), 32'd1);
        check("setup_rdwr", 32'({o_rd_n, o_wr_n}), 32'd3);
        check("setup_oe", 32'(o_data_oe), 32'(we));
        if (we) check("setup_data", 32'(sram_data), 32'(wd));
        for (int s = 0; s < 2; s++) begin
            tick();
            check("strobe_rdwr", 32'({o_rd_n, o_wr_n}), we ? 32'd2 : 32'd1);
            check("strobe_done", 32'(bus.done), 32'd0);
            check("strobe_oe", 32'(o_data_oe), 32'(we));
            if (we) check("strobe_data", 32'(sram_data), 32'(wd));
        end
        tick();
        check("hold_done", 32'(bus.done), 32'(1 << ch));
        check("hold_rdwr", 32'({o_rd_n, o_wr_n}), 32'd3);
        check("hold_rdata", 32'(bus.rdata), 32'(exp_rd));
        check("hold_oe", 32'(o_data_oe), 32'(we));
        if (we) check("hold_data", 32'(sram_data), 32'(wd));
        bus.req[ch] = 1'b0;
        tick();
        check("idle_busy", 32'(bus.busy), 32'd0);
        check("idle_done", 32'(bus.done), 32'd0);
        check("idle_oe", 32'(o_data_oe), 32'd0);
        check("idle_rdata", 32'(bus.rdata), 32'(exp_rd));
        $display("access ch=%0d we=%0d addr=0x%03h wdata=0x%02h rdata=0x%02h",
                 ch, we, addr, wd, bus.rdata);
    endtask

    typedef struct {
        int          ch;
        logic        we;
        logic [10:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  exp_rdata;
    } vec_t;

    vec_t vecs [8];

    initial begin
        int dch [4];
        int dcyc [4];
        int nd;
        int ndone;
        bit seen;

        vecs[0] = '{0, 1'b1, 11'h123, 8'hA5, 8'h00};
        vecs[1] = '{1, 1'b0, 11'h7FF, 8'h00, 8'h5A};
        vecs[2] = '{1, 1'b1, 11'h055, 8'h3C, 8'h5A};
        vecs[3] = '{0, 1'b0, 11'h123, 8'h00, 8'hA5};
        vecs[4] = '{0, 1'b0, 11'h055, 8'h00, 8'h3C};
        vecs[5] = '{1, 1'b1, 11'h7FF, 8'hC3, 8'h3C};
        vecs[6] = '{0, 1'b0, 11'h7FF, 8'h00, 8'hC3};
        vecs[7] = '{1, 1'b0, 11'h123, 8'h00, 8'hA5};

        rst_n     = 1'b0;
        mem_init  = 1'b1;
        bus.req   = 2'b00;
        bus.we    = 2'b00;
        bus.addr  = '0;
        bus.wdata = '0;
        tick();
        tick();
        mem_init = 1'b0;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_rdwr", 32'({o_rd_n, o_wr_n}), 32'd3);
        check("rst_oe", 32'(o_data_oe), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_rdata", 32'(bus.rdata), 32'd0);
        check("rst_addr", 32'(o_address), 32'd0);
        rst_n = 1'b1;
        tick();

        for (int v = 0; v < 8; v++) begin
            access(vecs[v].ch, vecs[v].we, vecs[v].addr, vecs[v].wdata, vecs[v].exp_rdata);
        end

        // Late drop: request and address change during STROBE must not affect the access.
        bus.req[0] = 1'b1; bus.we[0] = 1'b1; bus.addr[0] = 11'h200; bus.wdata[0] = 8'h77;
        tick();
        check("drop_setup_addr", 32'(o_address), 32'h200);
        tick();
        check("drop_strobe_wr", 32'(o_wr_n), 32'd0);
        bus.req[0] = 1'b0; bus.addr[0] = 11'h000; bus.wdata[0] = 8'h00;
        ndone = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (bus.done[0]) ndone++;
            if (bus.busy) check("drop_addr", 32'(o_address), 32'h200);
            if (o_data_oe) check("drop_data", 32'(sram_data), 32'h77);
        end
        check("drop_done_count", 32'(ndone), 32'd1);
        $display("late-drop write ch=0 addr=0x200 done_pulses=%0d", ndone);
        access(0, 1'b0, 11'h200, 8'h00, 8'h77);
        access(1, 1'b0, 11'h000, 8'h00, 8'h00);

        // Contention from reset: both channels request continuously.
        rst_n     = 1'b0;
        bus.req   = 2'b11;
        bus.we    = 2'b00;
        bus.addr[0] = 11'h7FF;
        bus.addr[1] = 11'h123;
        tick();
        rst_n = 1'b1;
        nd = 0;
        for (int c = 0; c < 40 && nd < 4; c++) begin
            tick();
            if (bus.done != 2'b00) begin
                check("cont_onehot", 32'(bus.done == 2'b11), 32'd0);
                dch[nd]  = bus.done[1] ? 1 : 0;
                dcyc[nd] = c;
                $display("contention done ch=%0d cycle=%0d rdata=0x%02h", dch[nd], c, bus.rdata);
                nd++;
            end
        end
        bus.req = 2'b00;
        check("cont_count", 32'(nd), 32'd4);
        for (int k = 0; k < nd; k++) begin
            check("cont_order", 32'(dch[k]), 32'(k % 2));
            if (k > 0) check("cont_gap", 32'(dcyc[k] - dcyc[k-1]), 32'd5);
        end
        tick();
        tick();

        // Reset in the middle of a write strobe.
        bus.req[1] = 1'b1; bus.we[1] = 1'b1; bus.addr[1] = 11'h010; bus.wdata[1] = 8'h99;
        seen = 1'b0;
        for (int c = 0; c < 8 && !seen; c++) begin
            tick();
            if (!o_wr_n) seen = 1'b1;
        end
        check("mrst_reached_strobe", 32'(seen), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mrst_wr", 32'(o_wr_n), 32'd1);
        check("mrst_rd", 32'(o_rd_n), 32'd1);
        check("mrst_oe", 32'(o_data_oe), 32'd0);
        check("mrst_busy", 32'(bus.busy), 32'd0);
        bus.req = 2'b00;
        tick();
        tick();
        rst_n = 1'b1;
        ndone = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (bus.done != 2'b00) ndone++;
        end
        check("mrst_no_done", 32'(ndone), 32'd0);
        check("mrst_idle", 32'(bus.busy), 32'd0);
        $display("mid-access reset ch=1 addr=0x010 done_after_reset=%0d", ndone);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
